ex_mem_stage_reg: RTL and testbench

//  EX/MEM pipeline register of the 5-stage flow CPU; sits directly downstream of the ALU.

---
 rtl/flow_cpu_pkg.sv | 45 ++++
 rtl/ex_mem_stage_reg.sv | 156 +++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/flow_cpu_pkg.sv
// Shared constants and types for the 5-stage flow CPU: datapath defaults,
// exception codes, ALU opcodes and EX/MEM gating helpers.
package flow_cpu_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  localparam logic [4:0] EXC_OV = 5'h0C;

  // ALU operation codes shared by ID decode and the ALU
  localparam logic [3:0] ALUC_ADDU = 4'h0;
  localparam logic [3:0] ALUC_ADD  = 4'h1;
  localparam logic [3:0] ALUC_SUBU = 4'h2;
  localparam logic [3:0] ALUC_SUB  = 4'h3;
  localparam logic [3:0] ALUC_AND  = 4'h4;
  localparam logic [3:0] ALUC_OR   = 4'h5;
  localparam logic [3:0] ALUC_XOR  = 4'h6;
  localparam logic [3:0] ALUC_NOR  = 4'h7;
  localparam logic [3:0] ALUC_SLT  = 4'h8;
  localparam logic [3:0] ALUC_SLTU = 4'h9;
  localparam logic [3:0] ALUC_SLL  = 4'hA;
  localparam logic [3:0] ALUC_SRL  = 4'hB;
  localparam logic [3:0] ALUC_SRA  = 4'hC;
  localparam logic [3:0] ALUC_LUI  = 4'hD;
  localparam logic [3:0] ALUC_MOVZ = 4'hE;
  localparam logic [3:0] ALUC_MOVN = 4'hF;

  typedef enum logic {
    TRAP_IDLE = 1'b0,
    TRAP_PEND = 1'b1
  } trap_state_e;

  // Register write survives only for a live slot whose move condition held
  // and whose arithmetic did not overflow.
  function automatic logic f_rf_we(input logic valid, input logic we,
                                   input logic not_move, input logic ovf);
    return valid & we & ~not_move & ~ovf;
  endfunction

  function automatic logic f_mem_strobe(input logic valid, input logic strobe,
                                        input logic ovf);
    return valid & strobe & ~ovf;
  endfunction

endpackage

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with write/strobe gating and MEM->EX forwarding.
// Define ALU_OVF_TRAP_EN to add the overflow trap FSM and exc_* ports.
module ex_mem_stage_reg
  import flow_cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_pc,
  input  logic [DW-1:0] ex_alu_r,
  input  logic          ex_zero,
  input  logic          ex_not_move,
  input  logic          ex_overflow,
  input  logic          ex_rf_w,
  input  logic [RW-1:0] ex_rf_dst,
  input  logic          ex_mem_r,
  input  logic          ex_mem_w,
  input  logic [DW-1:0] ex_store_data,
  output logic          mem_valid,
  output logic [DW-1:0] mem_pc,
  output logic [DW-1:0] mem_alu_r,
  output logic          mem_zero,
  output logic          mem_rf_w,
  output logic [RW-1:0] mem_rf_dst,
  output logic          mem_mem_r,
  output logic          mem_mem_w,
  output logic [DW-1:0] mem_store_data,
  output logic          fwd_en,
  output logic [RW-1:0] fwd_dst,
  output logic [DW-1:0] fwd_data
`ifdef ALU_OVF_TRAP_EN
  ,
  input  logic          exc_ack,
  output logic          exc_req,
  output logic [DW-1:0] exc_epc,
  output logic [4:0]    exc_code
`endif
);

  logic          r_valid;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_alu_r;
  logic          r_zero;
  logic          r_rf_w;
  logic [RW-1:0] r_rf_dst;
  logic          r_mem_r;
  logic          r_mem_w;
  logic [DW-1:0] r_store_data;

  logic w_load;
  logic w_squash;
  logic w_slot_live;

  assign w_load      = ~flush & ~stall;
  assign w_slot_live = ex_valid & ~w_squash;

`ifdef ALU_OVF_TRAP_EN
  trap_state_e   r_state;
  trap_state_e   w_state_nxt;
  logic          w_trap_take;
  logic          w_exc_req;
  logic [DW-1:0] r_exc_epc;
  logic [4:0]    r_exc_code;

  // The faulting slot and everything younger than it retire as bubbles
  // until CP0 acknowledges the exception.
  assign w_squash    = (r_state == TRAP_PEND) | (ex_valid & ex_overflow);
  assign w_trap_take = w_load & ex_valid & ex_overflow & (r_state == TRAP_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= TRAP_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TRAP_IDLE: if (w_trap_take) w_state_nxt = TRAP_PEND;
      TRAP_PEND: if (exc_ack)     w_state_nxt = TRAP_IDLE;
      default:                    w_state_nxt = TRAP_IDLE;
    endcase
  end

  always_comb begin
    w_exc_req = 1'b0;
    if (r_state == TRAP_PEND) w_exc_req = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc_epc  <= '0;
      r_exc_code <= '0;
    end else if (w_trap_take) begin
      r_exc_epc  <= ex_pc;
      r_exc_code <= EXC_OV;
    end
  end

  assign exc_req  = w_exc_req;
  assign exc_epc  = r_exc_epc;
  assign exc_code = r_exc_code;
`else
  assign w_squash = 1'b0;
`endif

  // EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_alu_r      <= '0;
      r_zero       <= 1'b0;
      r_rf_w       <= 1'b0;
      r_rf_dst     <= '0;
      r_mem_r      <= 1'b0;
      r_mem_w      <= 1'b0;
      r_store_data <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_rf_w  <= 1'b0;
      r_mem_r <= 1'b0;
      r_mem_w <= 1'b0;
    end else if (w_load) begin
      r_valid      <= w_slot_live;
      r_pc         <= ex_pc;
      r_alu_r      <= ex_alu_r;
      r_zero       <= ex_zero;
      r_rf_w       <= f_rf_we(w_slot_live, ex_rf_w, ex_not_move, ex_overflow);
      r_rf_dst     <= ex_rf_dst;
      r_mem_r      <= f_mem_strobe(w_slot_live, ex_mem_r, ex_overflow);
      r_mem_w      <= f_mem_strobe(w_slot_live, ex_mem_w, ex_overflow);
      r_store_data <= ex_store_data;
    end
  end

  assign mem_valid      = r_valid;
  assign mem_pc         = r_pc;
  assign mem_alu_r      = r_alu_r;
  assign mem_zero       = r_zero;
  assign mem_rf_w       = r_rf_w;
  assign mem_rf_dst     = r_rf_dst;
  assign mem_mem_r      = r_mem_r;
  assign mem_mem_w      = r_mem_w;
  assign mem_store_data = r_store_data;

  // Loads are not forwarded from here: their data only exists after MEM.
  assign fwd_en   = r_valid & r_rf_w & ~r_mem_r & (r_rf_dst != '0);
  assign fwd_dst  = r_rf_dst;
  assign fwd_data = r_alu_r;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed self-checking bench for ex_mem_stage_reg; follows ALU_OVF_TRAP_EN.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid, ex_zero, ex_not_move, ex_overflow, ex_rf_w, ex_mem_r, ex_mem_w;
  logic [31:0] ex_pc, ex_alu_r, ex_store_data;
  logic [4:0]  ex_rf_dst;
  logic        mem_valid, mem_zero, mem_rf_w, mem_mem_r, mem_mem_w, fwd_en;
  logic [31:0] mem_pc, mem_alu_r, mem_store_data, fwd_data;
  logic [4:0]  mem_rf_dst, fwd_dst;
`ifdef ALU_OVF_TRAP_EN
  logic        exc_ack, exc_req;
  logic [31:0] exc_epc;
  logic [4:0]  exc_code;
`endif

  int n_total  = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_r(ex_alu_r), .ex_zero(ex_zero),
    .ex_not_move(ex_not_move), .ex_overflow(ex_overflow), .ex_rf_w(ex_rf_w),
    .ex_rf_dst(ex_rf_dst), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_r(mem_alu_r), .mem_zero(mem_zero),
    .mem_rf_w(mem_rf_w), .mem_rf_dst(mem_rf_dst), .mem_mem_r(mem_mem_r),
    .mem_mem_w(mem_mem_w), .mem_store_data(mem_store_data),
    .fwd_en(fwd_en), .fwd_dst(fwd_dst), .fwd_data(fwd_data)
`ifdef ALU_OVF_TRAP_EN
    , .exc_ack(exc_ack), .exc_req(exc_req), .exc_epc(exc_epc), .exc_code(exc_code)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] r, input logic we,
                           input logic [4:0] dst, input logic ld, input logic st);
    ex_valid = 1'b1; ex_pc = pc; ex_alu_r = r; ex_rf_w = we; ex_rf_dst = dst;
    ex_mem_r = ld; ex_mem_w = st; ex_not_move = 1'b0; ex_overflow = 1'b0;
    ex_zero = (r == 32'h0); ex_store_data = r ^ 32'hA5A5_0000;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
`ifdef ALU_OVF_TRAP_EN
    exc_ack = 1'b0;
`endif
    set_instr(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 5'd3, 1'b0, 1'b1);

    // Reset held two cycles with a live EX slot
    step(); step();
    check("rst_valid", {31'b0, mem_valid}, 32'h0);
    check("rst_pc", mem_pc, 32'h0);
    check("rst_alu_r", mem_alu_r, 32'h0);
    check("rst_rf_w", {31'b0, mem_rf_w}, 32'h0);
    check("rst_mem_w", {31'b0, mem_mem_w}, 32'h0);
    check("rst_store", mem_store_data, 32'h0);
    check("rst_fwd_en", {31'b0, fwd_en}, 32'h0);
`ifdef ALU_OVF_TRAP_EN
    check("rst_exc_req", {31'b0, exc_req}, 32'h0);
    check("rst_exc_epc", exc_epc, 32'h0);
    check("rst_exc_code", {27'b0, exc_code}, 32'h0);
`endif

    rst = 1'b0;
    step();
    check("first_alu_r", mem_alu_r, 32'hDEAD_BEEF);
    check("first_valid", {31'b0, mem_valid}, 32'h1);
    check("first_mem_w", {31'b0, mem_mem_w}, 32'h1);
    check("first_store", mem_store_data, 32'h7B08_BEEF);

    // addu r5 = 0x10
    set_instr(32'h0000_0104, 32'h0000_0010, 1'b1, 5'd5, 1'b0, 1'b0);
    step();
    check("addu_rf_w", {31'b0, mem_rf_w}, 32'h1);
    check("addu_fwd_en", {31'b0, fwd_en}, 32'h1);
    check("addu_fwd_dst", {27'b0, fwd_dst}, 32'h5);
    check("addu_fwd_data", fwd_data, 32'h10);
    check("addu_pc", mem_pc, 32'h104);
    check("addu_mem_w", {31'b0, mem_mem_w}, 32'h0);

    // Load: write enabled but not forwardable
    set_instr(32'h0000_0108, 32'h0000_2000, 1'b1, 5'd6, 1'b1, 1'b0);
    step();
    check("ld_mem_r", {31'b0, mem_mem_r}, 32'h1);
    check("ld_rf_w", {31'b0, mem_rf_w}, 32'h1);
    check("ld_fwd_en", {31'b0, fwd_en}, 32'h0);

    // Destination $0
    set_instr(32'h0000_010C, 32'h0000_0033, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    check("r0_rf_w", {31'b0, mem_rf_w}, 32'h1);
    check("r0_fwd_en", {31'b0, fwd_en}, 32'h0);

    // movz with false condition
    set_instr(32'h0000_0110, 32'h0000_0044, 1'b1, 5'd8, 1'b0, 1'b0);
    ex_not_move = 1'b1;
    step();
    check("movz_valid", {31'b0, mem_valid}, 32'h1);
    check("movz_rf_w", {31'b0, mem_rf_w}, 32'h0);
    check("movz_fwd_en", {31'b0, fwd_en}, 32'h0);

    // Invalid EX slot
    set_instr(32'h0000_0114, 32'h0000_0055, 1'b1, 5'd9, 1'b0, 1'b1);
    ex_valid = 1'b0;
    step();
    check("inv_valid", {31'b0, mem_valid}, 32'h0);
    check("inv_rf_w", {31'b0, mem_rf_w}, 32'h0);
    check("inv_mem_w", {31'b0, mem_mem_w}, 32'h0);

    // Stall three cycles with changing inputs, then stall+flush
    set_instr(32'h0000_0120, 32'h0000_0030, 1'b1, 5'd9, 1'b0, 1'b0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(32'h0000_0200 + 32'(i * 4), 32'h0000_0900 + 32'(i), 1'b1, 5'd12, 1'b0, 1'b1);
      step();
      check("stall_alu_r", mem_alu_r, 32'h30);
      check("stall_pc", mem_pc, 32'h120);
      check("stall_valid", {31'b0, mem_valid}, 32'h1);
      check("stall_mem_w", {31'b0, mem_mem_w}, 32'h0);
    end
    flush = 1'b1;
    step();
    check("sflush_valid", {31'b0, mem_valid}, 32'h0);
    check("sflush_rf_w", {31'b0, mem_rf_w}, 32'h0);
    check("sflush_fwd_en", {31'b0, fwd_en}, 32'h0);
    stall = 1'b0; flush = 1'b0;
    set_instr(32'h0000_0130, 32'h0000_0044, 1'b1, 5'd4, 1'b0, 1'b0);
    step();
    check("resume_valid", {31'b0, mem_valid}, 32'h1);
    check("resume_alu_r", mem_alu_r, 32'h44);

    // Overflowing add that would also store
    set_instr(32'h0040_0020, 32'h0000_0000, 1'b1, 5'd10, 1'b0, 1'b1);
    ex_overflow = 1'b1;
    step();
`ifdef ALU_OVF_TRAP_EN
    check("ovf_valid", {31'b0, mem_valid}, 32'h0);
    check("ovf_rf_w", {31'b0, mem_rf_w}, 32'h0);
    check("ovf_mem_w", {31'b0, mem_mem_w}, 32'h0);
    check("ovf_exc_req", {31'b0, exc_req}, 32'h1);
    check("ovf_exc_epc", exc_epc, 32'h0040_0020);
    check("ovf_exc_code", {27'b0, exc_code}, 32'h0C);

    set_instr(32'h0040_0024, 32'h0000_0077, 1'b1, 5'd11, 1'b0, 1'b0);
    step();
    check("pend1_valid", {31'b0, mem_valid}, 32'h0);
    check("pend1_rf_w", {31'b0, mem_rf_w}, 32'h0);
    set_instr(32'h0040_0028, 32'h0000_0078, 1'b1, 5'd12, 1'b0, 1'b1);
    step();
    check("pend2_valid", {31'b0, mem_valid}, 32'h0);
    check("pend2_mem_w", {31'b0, mem_mem_w}, 32'h0);
    check("pend2_exc_req", {31'b0, exc_req}, 32'h1);

    flush = 1'b1;
    step();
    flush = 1'b0;
    check("pend_flush_req", {31'b0, exc_req}, 32'h1);

    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("ack_exc_req", {31'b0, exc_req}, 32'h0);
    check("ack_valid", {31'b0, mem_valid}, 32'h0);
    check("ack_epc_hold", exc_epc, 32'h0040_0020);

    exc_ack = 1'b1;
    set_instr(32'h0000_0080, 32'h0000_0099, 1'b1, 5'd13, 1'b0, 1'b0);
    step();
    exc_ack = 1'b0;
    check("post_valid", {31'b0, mem_valid}, 32'h1);
    check("post_fwd_en", {31'b0, fwd_en}, 32'h1);
    check("post_exc_req", {31'b0, exc_req}, 32'h0);

    // Second trap cleared by reset
    set_instr(32'h0040_0100, 32'h0000_0000, 1'b1, 5'd14, 1'b0, 1'b0);
    ex_overflow = 1'b1;
    step();
    check("ovf2_epc", exc_epc, 32'h0040_0100);
    ex_overflow = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_req", {31'b0, exc_req}, 32'h0);
    check("rst_mid_epc", exc_epc, 32'h0);
    set_instr(32'h0000_0300, 32'h0000_0012, 1'b1, 5'd2, 1'b0, 1'b0);
    step();
    check("rst_mid_resume", {31'b0, mem_valid}, 32'h1);
`else
    check("ovf_valid", {31'b0, mem_valid}, 32'h1);
    check("ovf_rf_w", {31'b0, mem_rf_w}, 32'h0);
    check("ovf_mem_w", {31'b0, mem_mem_w}, 32'h0);
    check("ovf_fwd_en", {31'b0, fwd_en}, 32'h0);
    check("ovf_pc", mem_pc, 32'h0040_0020);

    set_instr(32'h0040_0024, 32'h0000_0077, 1'b1, 5'd11, 1'b0, 1'b0);
    step();
    check("after_ovf_valid", {31'b0, mem_valid}, 32'h1);
    check("after_ovf_fwd", {31'b0, fwd_en}, 32'h1);
`endif

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
